// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller port bundle: pipeline hazard inputs and the resulting stall/flush controls.
// The master side is the pipeline datapath. The slave side is the hazard controller.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
);
    logic              IDEX_MemRead_i;
    logic [REG_AW-1:0] IDEX_RTaddr_i;
    logic [REG_AW-1:0] IFID_RSaddr_i;
    logic [REG_AW-1:0] IFID_RTaddr_i;
    logic              IFID_UsesRT_i;
    logic              BranchTaken_i;
    logic              Jump_i;
    logic              PCWrite_o;
    logic              IFIDWrite_o;
    logic              IFIDFlush_o;
    logic              IDEXWrite_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  flush_cnt_o;

    modport master (
        output IDEX_MemRead_i, IDEX_RTaddr_i, IFID_RSaddr_i, IFID_RTaddr_i,
               IFID_UsesRT_i, BranchTaken_i, Jump_i,
        input  PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXWrite_o,
               stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  IDEX_MemRead_i, IDEX_RTaddr_i, IFID_RSaddr_i, IFID_RTaddr_i,
               IFID_UsesRT_i, BranchTaken_i, Jump_i,
        output PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXWrite_o,
               stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Load-use / redirect hazard controller for the 5-stage 16-bit pipeline.
// It drives the PC, IF/ID and ID/EX write controls and keeps saturating stall and flush counters.
module pipe_hazard_ctrl #(
    parameter int REG_AW          = 3,
    parameter int LU_STALL_CYCLES = 1,
    parameter int CNT_W           = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    pipe_hazard_ctrl_if.slave     hz
);
    typedef enum logic {RUN, LU_STALL} state_t;

    localparam logic [2:0] BCNT_INIT = 3'(LU_STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state_q, state_d;
    logic [2:0]        bcnt_q, bcnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
    logic [REG_AW-1:0] ex_rt;
    logic              lu, redir;
    logic              stall_inc, flush_inc;
    logic              pc_we, ifid_we, ifid_flush, idex_we;

    assign ex_rt = hz.IDEX_RTaddr_i;
    assign lu    = hz.IDEX_MemRead_i &
                   ((ex_rt == hz.IFID_RSaddr_i) |
                    (hz.IFID_UsesRT_i & (ex_rt == hz.IFID_RTaddr_i)));
    assign redir = hz.BranchTaken_i | hz.Jump_i;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            bcnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        case (state_q)
            RUN: begin
                if (!redir && lu && (LU_STALL_CYCLES > 1)) begin
                    state_d = LU_STALL;
                    bcnt_d  = BCNT_INIT;
                end
            end
            LU_STALL: begin
                // A redirect discards the stalled instruction, so the remaining bubbles are moot.
                if (redir || bcnt_q == 3'd1) begin
                    state_d = RUN;
                    bcnt_d  = 3'd0;
                end else begin
                    bcnt_d = bcnt_q - 3'd1;
                end
            end
            default: begin
                state_d = RUN;
                bcnt_d  = 3'd0;
            end
        endcase
    end

    always_comb begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        ifid_flush = 1'b0;
        idex_we    = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        if (rst_n) begin
            if (redir) begin
                pc_we      = 1'b1;
                ifid_we    = 1'b1;
                ifid_flush = 1'b1;
                flush_inc  = 1'b1;
            end else if (state_q == LU_STALL || lu) begin
                stall_inc = 1'b1;
            end else begin
                pc_we   = 1'b1;
                ifid_we = 1'b1;
                idex_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_inc && stall_cnt_q != CNT_MAX)
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush_inc && flush_cnt_q != CNT_MAX)
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign hz.PCWrite_o   = pc_we;
    assign hz.IFIDWrite_o = ifid_we;
    assign hz.IFIDFlush_o = ifid_flush;
    assign hz.IDEXWrite_o = idex_we;
    assign hz.stall_cnt_o = stall_cnt_q;
    assign hz.flush_cnt_o = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: three controllers share one stimulus set.
// The three instances are the default one, one with a 3-cycle stall, and one with 4-bit counters.
module tb_pipe_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mem_read, uses_rt, br, jmp;
    logic [2:0] idex_rt, ifid_rs, ifid_rt;
    int         checks = 0;
    int         errors = 0;

    pipe_hazard_ctrl_if #(.REG_AW(3), .CNT_W(16)) if_d ();
    pipe_hazard_ctrl_if #(.REG_AW(3), .CNT_W(16)) if_l ();
    pipe_hazard_ctrl_if #(.REG_AW(3), .CNT_W(4))  if_c ();

    // The same pipeline stimulus goes to every instance.
    assign {if_d.IDEX_MemRead_i, if_l.IDEX_MemRead_i, if_c.IDEX_MemRead_i} = {3{mem_read}};
    assign {if_d.IDEX_RTaddr_i,  if_l.IDEX_RTaddr_i,  if_c.IDEX_RTaddr_i}  = {3{idex_rt}};
    assign {if_d.IFID_RSaddr_i,  if_l.IFID_RSaddr_i,  if_c.IFID_RSaddr_i}  = {3{ifid_rs}};
    assign {if_d.IFID_RTaddr_i,  if_l.IFID_RTaddr_i,  if_c.IFID_RTaddr_i}  = {3{ifid_rt}};
    assign {if_d.IFID_UsesRT_i,  if_l.IFID_UsesRT_i,  if_c.IFID_UsesRT_i}  = {3{uses_rt}};
    assign {if_d.BranchTaken_i,  if_l.BranchTaken_i,  if_c.BranchTaken_i}  = {3{br}};
    assign {if_d.Jump_i,         if_l.Jump_i,         if_c.Jump_i}         = {3{jmp}};

    pipe_hazard_ctrl #(.REG_AW(3), .LU_STALL_CYCLES(1), .CNT_W(16)) u_d (
        .clk_i(clk), .rst_n(rst_n), .hz(if_d));
    pipe_hazard_ctrl #(.REG_AW(3), .LU_STALL_CYCLES(3), .CNT_W(16)) u_l (
        .clk_i(clk), .rst_n(rst_n), .hz(if_l));
    pipe_hazard_ctrl #(.REG_AW(3), .LU_STALL_CYCLES(1), .CNT_W(4))  u_c (
        .clk_i(clk), .rst_n(rst_n), .hz(if_c));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    // Outputs packed as {PCWrite, IFIDWrite, IFIDFlush, IDEXWrite}.
    function automatic logic [3:0] ctl_d();
        return {if_d.PCWrite_o, if_d.IFIDWrite_o, if_d.IFIDFlush_o, if_d.IDEXWrite_o};
    endfunction
    function automatic logic [3:0] ctl_l();
        return {if_l.PCWrite_o, if_l.IFIDWrite_o, if_l.IFIDFlush_o, if_l.IDEXWrite_o};
    endfunction

    task automatic idle();
        mem_read = 1'b0; uses_rt = 1'b0; br = 1'b0; jmp = 1'b0;
        idex_rt = 3'd3; ifid_rs = 3'd1; ifid_rt = 3'd2;
    endtask

    task automatic hazard();
        mem_read = 1'b1; uses_rt = 1'b0; br = 1'b0; jmp = 1'b0;
        idex_rt = 3'd3; ifid_rs = 3'd3; ifid_rt = 3'd1;
    endtask

    task automatic do_reset();
        @(negedge clk); idle(); rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk); idle(); rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctl_d() !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL reset_outputs cyc %0d got %b want 0000", i, ctl_d());
            end
            @(negedge clk);
        end
        rst_n = 1'b1; #1;
        checks++;
        if (ctl_d() !== 4'b1101) begin
            errors++; $display("[TB] FAIL post_reset_ctl got %b want 1101", ctl_d());
        end
        checks++;
        if (if_d.stall_cnt_o !== 16'd0 || if_d.flush_cnt_o !== 16'd0) begin
            errors++;
            $display("[TB] FAIL post_reset_cnt got %0d/%0d want 0/0", if_d.stall_cnt_o, if_d.flush_cnt_o);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge clk); hazard(); #1;
        checks++;
        if (ctl_d() !== 4'b0000) begin
            errors++; $display("[TB] FAIL lu_bubble got %b want 0000", ctl_d());
        end
        @(negedge clk); idle(); #1;
        checks++;
        if (ctl_d() !== 4'b1101) begin
            errors++; $display("[TB] FAIL lu_resume got %b want 1101", ctl_d());
        end
        checks++;
        if (if_d.stall_cnt_o !== 16'd1) begin
            errors++; $display("[TB] FAIL lu_stall_cnt got %0d want 1", if_d.stall_cnt_o);
        end
    endtask

    task automatic test_rt_use();
        do_reset();
        @(negedge clk);
        mem_read = 1'b1; idex_rt = 3'd5; ifid_rt = 3'd5; ifid_rs = 3'd2; uses_rt = 1'b0;
        #1;
        checks++;
        if (ctl_d() !== 4'b1101) begin
            errors++; $display("[TB] FAIL rt_unused got %b want 1101", ctl_d());
        end
        @(negedge clk); uses_rt = 1'b1; #1;
        checks++;
        if (ctl_d() !== 4'b0000) begin
            errors++; $display("[TB] FAIL rt_used got %b want 0000", ctl_d());
        end
        @(negedge clk); idle(); #1;
        checks++;
        if (if_d.stall_cnt_o !== 16'd1 || ctl_d() !== 4'b1101) begin
            errors++;
            $display("[TB] FAIL rt_after got cnt %0d ctl %b want 1 1101", if_d.stall_cnt_o, ctl_d());
        end
    endtask

    task automatic test_multi_stall();
        do_reset();
        @(negedge clk); hazard(); #1;
        checks++;
        if (ctl_l() !== 4'b0000) begin
            errors++; $display("[TB] FAIL ms_bubble1 got %b want 0000", ctl_l());
        end
        for (int i = 2; i <= 3; i++) begin
            @(negedge clk); idle(); #1;
            checks++;
            if (ctl_l() !== 4'b0000 || if_l.stall_cnt_o !== 16'(i - 1)) begin
                errors++;
                $display("[TB] FAIL ms_bubble%0d got ctl %b cnt %0d want 0000 %0d", i, ctl_l(), if_l.stall_cnt_o, i - 1);
            end
        end
        @(negedge clk); #1;
        checks++;
        if (ctl_l() !== 4'b1101 || if_l.stall_cnt_o !== 16'd3) begin
            errors++;
            $display("[TB] FAIL ms_resume got ctl %b cnt %0d want 1101 3", ctl_l(), if_l.stall_cnt_o);
        end
        checks++;
        if (if_d.stall_cnt_o !== 16'd1) begin
            errors++; $display("[TB] FAIL ms_default_cnt got %0d want 1", if_d.stall_cnt_o);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        @(negedge clk); hazard(); br = 1'b1; #1;
        checks++;
        if (ctl_d() !== 4'b1110) begin
            errors++; $display("[TB] FAIL br_flush got %b want 1110", ctl_d());
        end
        @(negedge clk); idle(); #1;
        checks++;
        if (if_d.flush_cnt_o !== 16'd1 || if_d.stall_cnt_o !== 16'd0) begin
            errors++;
            $display("[TB] FAIL br_cnts got flush %0d stall %0d want 1 0", if_d.flush_cnt_o, if_d.stall_cnt_o);
        end
        do_reset();
        @(negedge clk); hazard();
        @(negedge clk); idle(); jmp = 1'b1; #1;
        checks++;
        if (ctl_l() !== 4'b1110) begin
            errors++; $display("[TB] FAIL jmp_in_stall got %b want 1110", ctl_l());
        end
        @(negedge clk); idle(); #1;
        checks++;
        if (ctl_l() !== 4'b1101 || if_l.stall_cnt_o !== 16'd1 || if_l.flush_cnt_o !== 16'd1) begin
            errors++;
            $display("[TB] FAIL jmp_resume got ctl %b stall %0d flush %0d want 1101 1 1", ctl_l(), if_l.stall_cnt_o, if_l.flush_cnt_o);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); hazard();
            @(negedge clk); idle();
        end
        #1;
        checks++;
        if (if_c.stall_cnt_o !== 4'd15) begin
            errors++; $display("[TB] FAIL sat_stall got %0d want 15", if_c.stall_cnt_o);
        end
        checks++;
        if (if_d.stall_cnt_o !== 16'd20) begin
            errors++; $display("[TB] FAIL sat_wide got %0d want 20", if_d.stall_cnt_o);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        @(negedge clk); hazard();
        @(negedge clk); idle(); rst_n = 1'b0; #1;
        checks++;
        if (ctl_l() !== 4'b0000 || if_l.stall_cnt_o !== 16'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset got ctl %b cnt %0d want 0000 0", ctl_l(), if_l.stall_cnt_o);
        end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++;
        if (ctl_l() !== 4'b1101) begin
            errors++; $display("[TB] FAIL mid_reset_run got %b want 1101", ctl_l());
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_rt_use();
        test_multi_stall();
        test_redirect();
        test_saturate();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
